// File: rtl/if_fetch.sv
// Instruction fetch unit: assembles 32-bit little-endian instruction words from a
// byte-wide memory port, one outstanding request at a time, and presents them to IF/ID.
// Optional direct-mapped instruction cache is compiled in with `define ICACHE_EN.
module if_fetch #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int unsigned ICACHE_LINES = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic [5:0]  stall,
  input  logic        branch_flag,
  input  logic [31:0] branch_target,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_busy,
  input  logic        mem_valid,
  input  logic [7:0]  mem_data,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        stall_req
);

  typedef enum logic [2:0] {StIdle, StReq, StWait, StDone, StDrain} state_t;

  state_t      state;
  logic [31:0] pc;
  logic [1:0]  k;
  logic [23:0] instr_buf;  // bytes 0..2 of the word in flight, byte 0 lowest
  logic        req_q;
  logic        cache_hit;
  logic [31:0] hit_word;

  // Only stall[1] (IF/ID capture) concerns this stage.
  logic unused_stall;
  assign unused_stall = ^{stall[5:2], stall[0]};

  if (ICACHE_LINES < 2 || (ICACHE_LINES & (ICACHE_LINES - 1)) != 0) begin : g_lines_check
    $error("ICACHE_LINES must be a power of two >= 2");
  end

  // A request is never visible while the pipeline is frozen.
  assign mem_req = req_q & rdy;

`ifdef ICACHE_EN
  localparam int unsigned IdxW = $clog2(ICACHE_LINES);
  localparam int unsigned TagW = 30 - IdxW;

  logic [31:0]             cache_data [ICACHE_LINES];
  logic [TagW-1:0]         cache_tag  [ICACHE_LINES];
  logic [ICACHE_LINES-1:0] cache_valid;
  logic [IdxW-1:0]         pc_idx;
  logic [TagW-1:0]         pc_tag;
  logic                    fill;

  assign pc_idx    = pc[IdxW+1:2];
  assign pc_tag    = pc[31:IdxW+2];
  assign cache_hit = cache_valid[pc_idx] && (cache_tag[pc_idx] == pc_tag);
  assign hit_word  = cache_data[pc_idx];
  // A fill completes on the last byte of an unbranched miss, i.e. on entry to DONE.
  assign fill = rdy && !branch_flag && (state == StWait) && mem_valid && (k == 2'd3);

  // Valid bits: cleared by reset, set by each completed fill.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_valid <= '0;
    end else if (fill) begin
      cache_valid[pc_idx] <= 1'b1;
    end
  end

  // Line storage: data and tag written together on a fill.
  always_ff @(posedge clk) begin
    if (fill) begin
      cache_data[pc_idx] <= {mem_data, instr_buf};
      cache_tag[pc_idx]  <= pc_tag;
    end
  end
`else
  assign cache_hit = 1'b0;
  assign hit_word  = '0;
`endif

  // Fetch FSM with registered memory-request and IF/ID outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= StIdle;
      pc        <= RESET_PC;
      k         <= 2'd0;
      instr_buf <= '0;
      req_q     <= 1'b0;
      mem_addr  <= '0;
      if_pc     <= '0;
      if_instr  <= '0;
      stall_req <= 1'b1;
    end else if (rdy) begin
      if (branch_flag) begin
        pc        <= branch_target;
        k         <= 2'd0;
        req_q     <= 1'b0;
        stall_req <= 1'b1;
        // A byte still in flight must be swallowed before a new request goes out.
        if (((state == StWait || state == StDrain) && !mem_valid) ||
            (state == StReq && !mem_busy)) begin
          state <= StDrain;
        end else begin
          state <= StIdle;
        end
      end else begin
        unique case (state)
          StIdle: begin
            if (cache_hit) begin
              state     <= StDone;
              if_pc     <= pc;
              if_instr  <= hit_word;
              stall_req <= 1'b0;
            end else begin
              state    <= StReq;
              k        <= 2'd0;
              req_q    <= 1'b1;
              mem_addr <= pc;
            end
          end
          StReq: begin
            if (!mem_busy) begin
              req_q <= 1'b0;
              state <= StWait;
            end
          end
          StWait: begin
            if (mem_valid) begin
              if (k == 2'd3) begin
                state     <= StDone;
                if_pc     <= pc;
                if_instr  <= {mem_data, instr_buf};
                stall_req <= 1'b0;
              end else begin
                instr_buf <= {mem_data, instr_buf[23:8]};
                k         <= k + 2'd1;
                req_q     <= 1'b1;
                mem_addr  <= pc + {30'd0, k} + 32'd1;
                state     <= StReq;
              end
            end
          end
          StDone: begin
            if (!stall[1]) begin
              pc        <= pc + 32'd4;
              state     <= StIdle;
              stall_req <= 1'b1;
            end
          end
          StDrain: begin
            if (mem_valid) begin
              state <= StIdle;
            end
          end
          default: state <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed sequences, a vector table and a randomized
// run against a transaction-level model (expected PC stream plus byte-addressed memory).
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdy;
  logic [5:0]  stall;
  logic        branch_flag;
  logic [31:0] branch_target;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_busy;
  logic        mem_valid;
  logic [7:0]  mem_data;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        stall_req;

  always #5 clk = ~clk;

  if_fetch #(.RESET_PC(32'h0000_0000), .ICACHE_LINES(64)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .stall(stall),
    .branch_flag(branch_flag), .branch_target(branch_target),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_busy(mem_busy),
    .mem_valid(mem_valid), .mem_data(mem_data),
    .if_pc(if_pc), .if_instr(if_instr), .stall_req(stall_req)
  );

  int          n_checks = 0;
  int          n_fail = 0;
  bit          outst;       // memory responder holds an accepted request
  logic [31:0] oaddr;
  int          wcnt;
  int          lat_sel;     // 0: random latency 1..4, else fixed latency
  int          busy_left;
  int          busy_pct;
  int          n_accept = 0;
  logic [31:0] mpc;         // model: PC of the next instruction to be presented

  typedef struct {
    logic [31:0] tgt;
    int          lat;
    int          busy;
    logic [31:0] instr;
    logic [31:0] next;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [7:0] byte_at(logic [31:0] a);
    logic [7:0] s;
    if (a < 32'd4) begin
      case (a[1:0])
        2'd0:    s = 8'h13;
        2'd1:    s = 8'h05;
        default: s = 8'h00;
      endcase
    end else begin
      s = a[7:0] + a[15:8] + a[31:24] + 8'h11;
    end
    return s;
  endfunction

  function automatic logic [31:0] word_at(logic [31:0] a);
    return {byte_at(a + 32'd3), byte_at(a + 32'd2), byte_at(a + 32'd1), byte_at(a)};
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock cycle: drive responder, sample, score against the model, advance.
  task automatic step();
    mem_valid = 1'b0;
    mem_data  = 8'h00;
    if (rst && rdy && outst && wcnt == 0) begin
      mem_valid = 1'b1;
      mem_data  = byte_at(oaddr);
      outst     = 1'b0;
    end
    mem_busy = (busy_left > 0) || (int'($urandom_range(0, 99)) < busy_pct);
    #1;
    if (rst) begin
      if (!rdy) chk("mem_req_frozen", {31'd0, mem_req}, 32'd0);
      if (mem_req && !mem_busy) begin
        chk("single_outstanding", {31'd0, outst}, 32'd0);
        chk("req_addr_in_word", {31'd0, (mem_addr - mpc) < 32'd4}, 32'd1);
        outst = 1'b1;
        oaddr = mem_addr;
        wcnt  = (lat_sel == 0) ? int'($urandom_range(0, 3)) : lat_sel - 1;
        n_accept++;
      end else if (outst && wcnt > 0 && rdy) begin
        wcnt--;
      end
      if (!stall_req) begin
        chk("present_pc", if_pc, mpc);
        chk("present_instr", if_instr, word_at(mpc));
      end
      if (rdy) begin
        if (branch_flag) mpc = branch_target;
        else if (!stall_req && !stall[1]) mpc = mpc + 32'd4;
      end
      if (busy_left > 0 && mem_req) busy_left--;
    end
    @(negedge clk);
  endtask

  task automatic wait_present(string name);
    int n = 0;
    while (stall_req && n < 300) begin
      step();
      n++;
    end
    chk({name, "_present_timeout"}, {31'd0, stall_req}, 32'd0);
  endtask

  task automatic wait_req(string name);
    int n = 0;
    while (!mem_req && n < 300) begin
      step();
      n++;
    end
    chk({name, "_req_timeout"}, {31'd0, mem_req}, 32'd1);
  endtask

  initial begin
    int          n;
    int          gap;
    int          max_gap;
    int          n0;
    logic [31:0] a0;

    vecs[0] = '{tgt: 32'h0000_0040, lat: 1, busy: 0, instr: 32'h5453_5251, next: 32'h0000_0044};
    vecs[1] = '{tgt: 32'h0000_0100, lat: 2, busy: 3, instr: 32'h1514_1312, next: 32'h0000_0104};
    vecs[2] = '{tgt: 32'h0000_0008, lat: 3, busy: 1, instr: 32'h1C1B_1A19, next: 32'h0000_000C};
    vecs[3] = '{tgt: 32'hFFFF_FFFC, lat: 1, busy: 2, instr: 32'h0E0D_0C0B, next: 32'h0000_0000};
    vecs[4] = '{tgt: 32'h0000_0000, lat: 2, busy: 0, instr: 32'h0000_0513, next: 32'h0000_0004};

    rst = 1'b0; rdy = 1'b1; stall = '0; branch_flag = 1'b0; branch_target = '0;
    mem_busy = 1'b0; mem_valid = 1'b0; mem_data = '0;
    outst = 1'b0; oaddr = '0; wcnt = 0; lat_sel = 1; busy_left = 0; busy_pct = 0;
    mpc = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_if_pc", if_pc, 32'd0);
    chk("rst_if_instr", if_instr, 32'd0);
    chk("rst_stall_req", {31'd0, stall_req}, 32'd1);
    rst = 1'b1;

    // First word after reset, latency 1.
    wait_present("first");
    chk("first_pc", if_pc, 32'h0);
    chk("first_instr", if_instr, 32'h0000_0513);
    step();
    chk("done_one_cycle", {31'd0, stall_req}, 32'd1);
    wait_req("second");
    chk("second_addr", mem_addr, 32'h4);

    // Hold DONE with stall[1] for three cycles.
    stall = 6'b000010;
    wait_present("held");
    chk("held_pc", if_pc, 32'h4);
    chk("held_instr", if_instr, 32'h1817_1615);
    repeat (3) begin
      step();
      chk("hold_pc", if_pc, 32'h4);
      chk("hold_instr", if_instr, 32'h1817_1615);
      chk("hold_stall_req", {31'd0, stall_req}, 32'd0);
      chk("hold_no_req", {31'd0, mem_req}, 32'd0);
    end
    stall = '0;
    step();
    wait_req("after_hold");
    chk("after_hold_addr", mem_addr, 32'h8);

    // Branch while waiting for byte 2 of the word at 0x8.
    lat_sel = 3;
    n = 0;
    while (!(outst && oaddr == 32'hA) && n < 100) begin
      step();
      n++;
    end
    chk("byte2_wait", {31'd0, outst && oaddr == 32'hA}, 32'd1);
    branch_flag = 1'b1;
    branch_target = 32'h100;
    step();
    branch_flag = 1'b0;
    n = 0;
    while (!mem_req && n < 100) begin
      chk("no_partial_word", {31'd0, stall_req}, 32'd1);
      step();
      n++;
    end
    chk("late_byte_drained", {31'd0, outst}, 32'd0);
    chk("branch_addr", mem_addr, 32'h100);
    lat_sel = 1;
    wait_present("branch_word");
    chk("branch_pc", if_pc, 32'h100);
    chk("branch_instr", if_instr, 32'h1514_1312);

    // Five busy cycles on the first byte of 0x104.
    busy_left = 5;
    step();
    wait_req("busy");
    n0 = n_accept;
    a0 = 32'h104;
    repeat (5) begin
      chk("busy_req_held", {31'd0, mem_req}, 32'd1);
      chk("busy_addr_held", mem_addr, a0);
      step();
    end
    step();
    chk("busy_single_accept", n_accept, n0 + 1);

    // Vector table: redirect, fetch, consume, check the follow-on address.
    foreach (vecs[i]) begin
      branch_flag = 1'b1;
      branch_target = vecs[i].tgt;
      step();
      branch_flag = 1'b0;
      lat_sel = vecs[i].lat;
      busy_left = vecs[i].busy;
      wait_present("vec");
      chk("vec_pc", if_pc, vecs[i].tgt);
      chk("vec_instr", if_instr, vecs[i].instr);
      step();
      wait_req("vec_next");
      chk("vec_next_addr", mem_addr, vecs[i].next);
    end

    // Asynchronous reset in the middle of a fetch.
    lat_sel = 3;
    n = 0;
    while (!outst && n < 100) begin
      step();
      n++;
    end
    #3;
    rst = 1'b0;
    outst = 1'b0;
    mpc = 32'h0;
    #1;
    chk("midrst_stall_req", {31'd0, stall_req}, 32'd1);
    chk("midrst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("midrst_mem_addr", mem_addr, 32'd0);
    chk("midrst_if_pc", if_pc, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    lat_sel = 1;
    wait_present("midrst");
    chk("midrst_pc", if_pc, 32'h0);
    chk("midrst_instr", if_instr, 32'h0000_0513);

`ifdef ICACHE_EN
    // Loop 0x0 -> 0x4 -> branch 0x0: second pass must hit without memory traffic.
    step();
    wait_present("loop4");
    branch_flag = 1'b1;
    branch_target = 32'h0;
    step();
    branch_flag = 1'b0;
    n0 = n_accept;
    step();
    chk("hit0_fast", {31'd0, stall_req}, 32'd0);
    chk("hit0_pc", if_pc, 32'h0);
    step();
    step();
    chk("hit4_fast", {31'd0, stall_req}, 32'd0);
    chk("hit4_pc", if_pc, 32'h4);
    chk("hit_no_mem", n_accept, n0);
`endif

    // Randomized run scored by the model inside step().
    busy_pct = 30;
    lat_sel = 0;
    gap = 0;
    max_gap = 0;
    for (int i = 0; i < 3000; i++) begin
      rdy = ($urandom_range(0, 9) != 0);
      stall = 6'($urandom);
      stall[1] = ($urandom_range(0, 4) == 0);
      branch_flag = ($urandom_range(0, 32) == 0);
      branch_target = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC :
                      {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      if (!stall_req || (rdy && branch_flag)) gap = 0;
      else gap++;
      if (gap > max_gap) max_gap = gap;
      step();
    end
    rdy = 1'b1; stall = '0; branch_flag = 1'b0; busy_pct = 0; lat_sel = 1;
    chk("liveness_gap", {31'd0, max_gap > 400}, 32'd0);
    wait_present("final");

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
